// File: rtl/wb_select_pkg.sv
// Shared types for the writeback stage: result-source select, load funct3 codes, FSM states.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_UIMM = 2'b11
  } wbsel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_LOAD = 2'b01,
    WRITE     = 2'b10
  } wb_state_e;

endpackage

// File: rtl/wb_select_if.sv
// MEM-to-WB bus plus register-file write port. Members are named from the stage's point of view.
// The bypass signals exist only when WB_FWD_EN is defined.
interface wb_select_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RF_ADDR_W = 5
);
  logic                 valid_i;
  logic                 ready_o;
  logic                 regwrite_i;
  logic [1:0]           wbsel_i;
  logic [RF_ADDR_W-1:0] rd_addr_i;
  logic [XLEN-1:0]      alu_result_i;
  logic [XLEN-1:0]      pc_i;
  logic [XLEN-1:0]      utypeimm_i;
  logic [2:0]           funct3_i;
  logic [1:0]           addr_lo_i;
  logic [XLEN-1:0]      load_data_i;
  logic                 load_valid_i;
  logic                 rf_we_o;
  logic [RF_ADDR_W-1:0] rf_waddr_o;
  logic [XLEN-1:0]      rf_wdata_o;
`ifdef WB_FWD_EN
  logic                 fwd_valid_o;
  logic [RF_ADDR_W-1:0] fwd_addr_o;
  logic [XLEN-1:0]      fwd_data_o;
`endif

  modport slave (
    input  valid_i, regwrite_i, wbsel_i, rd_addr_i, alu_result_i, pc_i, utypeimm_i,
           funct3_i, addr_lo_i, load_data_i, load_valid_i,
    output ready_o, rf_we_o, rf_waddr_o, rf_wdata_o
`ifdef WB_FWD_EN
    , output fwd_valid_o, fwd_addr_o, fwd_data_o
`endif
  );

  modport master (
    output valid_i, regwrite_i, wbsel_i, rd_addr_i, alu_result_i, pc_i, utypeimm_i,
           funct3_i, addr_lo_i, load_data_i, load_valid_i,
    input  ready_o, rf_we_o, rf_waddr_o, rf_wdata_o
`ifdef WB_FWD_EN
    , input fwd_valid_o, fwd_addr_o, fwd_data_o
`endif
  );

endinterface

// File: rtl/wb_select_load_extend.sv
// Combinational load-data alignment: byte/halfword/word select by offset, then sign/zero extend.
module load_extend
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = data_i[7:0];
    unique case (addr_lo_i)
      2'd0: byte_sel = data_i[7:0];
      2'd1: byte_sel = data_i[15:8];
      2'd2: byte_sel = data_i[23:16];
      2'd3: byte_sel = data_i[31:24];
      default: byte_sel = data_i[7:0];
    endcase
    // Misaligned halfword offsets fall back to the containing halfword.
    half_sel = addr_lo_i[1] ? data_i[31:16] : data_i[15:0];
  end

  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_sel};
      F3_LW:   data_o = data_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/wb_select.sv
// Writeback stage: selects the result source, extends load data, stalls for late loads.
// Optional bypass ports are enabled with WB_FWD_EN.
module wb_select
  import wb_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RF_ADDR_W = 5
) (
  input logic        clk_i,
  input logic        rst_i,
  wb_select_if.slave bus
);

  wb_state_e            state_q, state_d;
  logic                 regwrite_q, regwrite_d;
  logic [RF_ADDR_W-1:0] rd_q, rd_d;
  logic [2:0]           funct3_q, funct3_d;
  logic [1:0]           addr_lo_q, addr_lo_d;
  logic [XLEN-1:0]      wdata_q, wdata_d;

  logic            accept;
  logic            is_load;
  logic            waiting;
  logic            commit;
  logic [2:0]      ext_funct3;
  logic [1:0]      ext_addr_lo;
  logic [XLEN-1:0] ext_data;
  logic [XLEN-1:0] result;

  assign waiting = (state_q == WAIT_LOAD);
  assign accept  = bus.valid_i && !waiting;
  assign is_load = (wbsel_e'(bus.wbsel_i) == WB_LOAD);
  // A result becomes final either on accept (unless stalled on memory) or when the load returns.
  assign commit  = (accept && (!is_load || bus.load_valid_i)) || (waiting && bus.load_valid_i);

  assign ext_funct3  = waiting ? funct3_q : bus.funct3_i;
  assign ext_addr_lo = waiting ? addr_lo_q : bus.addr_lo_i;

  load_extend #(
    .XLEN (XLEN)
  ) u_load_extend (
    .funct3_i  (ext_funct3),
    .addr_lo_i (ext_addr_lo),
    .data_i    (bus.load_data_i),
    .data_o    (ext_data)
  );

  always_comb begin
    result = '0;
    if (waiting) begin
      result = ext_data;
    end else begin
      unique case (wbsel_e'(bus.wbsel_i))
        WB_ALU:  result = bus.alu_result_i;
        WB_LOAD: result = ext_data;
        WB_PC4:  result = bus.pc_i + XLEN'(4);
        WB_UIMM: result = bus.utypeimm_i;
        default: result = '0;
      endcase
    end
  end

  always_comb begin
    regwrite_d = regwrite_q;
    rd_d       = rd_q;
    funct3_d   = funct3_q;
    addr_lo_d  = addr_lo_q;
    wdata_d    = wdata_q;
    if (accept) begin
      regwrite_d = bus.regwrite_i;
      rd_d       = bus.rd_addr_i;
      funct3_d   = bus.funct3_i;
      addr_lo_d  = bus.addr_lo_i;
    end
    if (commit) begin
      wdata_d = result;
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      funct3_q   <= '0;
      addr_lo_q  <= '0;
      wdata_q    <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      funct3_q   <= funct3_d;
      addr_lo_q  <= addr_lo_d;
      wdata_q    <= wdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, WRITE: begin
        if (accept) begin
          state_d = (is_load && !bus.load_valid_i) ? WAIT_LOAD : WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_LOAD: begin
        if (bus.load_valid_i) begin
          state_d = WRITE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.ready_o    = !waiting;
    bus.rf_we_o    = (state_q == WRITE) && regwrite_q && (rd_q != '0);
    bus.rf_waddr_o = rd_q;
    bus.rf_wdata_o = wdata_q;
  end

`ifdef WB_FWD_EN
  logic                 fwd_regwrite;
  logic [RF_ADDR_W-1:0] fwd_rd;

  always_comb begin
    fwd_regwrite    = waiting ? regwrite_q : bus.regwrite_i;
    fwd_rd          = waiting ? rd_q : bus.rd_addr_i;
    bus.fwd_valid_o = commit && fwd_regwrite && (fwd_rd != '0);
    bus.fwd_addr_o  = commit ? fwd_rd : '0;
    bus.fwd_data_o  = commit ? result : '0;
  end
`endif

endmodule

// File: tb/tb_wb_select.sv
// Directed, table-driven bench for wb_select: single-cycle results, load stall, back-to-back, reset.
module tb_wb_select;

  logic clk;
  logic rst;

  wb_select_if #(.XLEN(32), .RF_ADDR_W(5)) bus ();

  wb_select #(
    .XLEN      (32),
    .RF_ADDR_W (5)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] uimm;
    logic [2:0]  f3;
    logic [1:0]  alo;
    logic [31:0] ld;
    logic        we;
    logic [31:0] data;
  } vec_t;

  localparam int NumVec = 12;
  vec_t vecs [NumVec];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v, input logic lv);
    bus.valid_i      = 1'b1;
    bus.regwrite_i   = v.rw;
    bus.wbsel_i      = v.sel;
    bus.rd_addr_i    = v.rd;
    bus.alu_result_i = v.alu;
    bus.pc_i         = v.pc;
    bus.utypeimm_i   = v.uimm;
    bus.funct3_i     = v.f3;
    bus.addr_lo_i    = v.alo;
    bus.load_data_i  = v.ld;
    bus.load_valid_i = lv;
  endtask

  task automatic idle_in();
    bus.valid_i      = 1'b0;
    bus.load_valid_i = 1'b0;
  endtask

  task automatic check_write(input string name, input logic we, input logic [4:0] rd,
                             input logic [31:0] data);
    check({name, " we"}, 32'(bus.rf_we_o), 32'(we));
    check({name, " waddr"}, 32'(bus.rf_waddr_o), 32'(rd));
    check({name, " wdata"}, bus.rf_wdata_o, data);
  endtask

  initial begin
    vec_t v;
    //          rw    sel    rd     alu           pc            uimm          f3      alo    ld            we    data
    vecs[0]  = '{1'b1, 2'b00, 5'd5,  32'h0000_1234, 32'h0,        32'h0,        3'b000, 2'd0, 32'h0,        1'b1, 32'h0000_1234};
    vecs[1]  = '{1'b1, 2'b01, 5'd6,  32'h0,        32'h0,        32'h0,        3'b101, 2'd2, 32'hBEEF_0000, 1'b1, 32'h0000_BEEF};
    vecs[2]  = '{1'b1, 2'b10, 5'd1,  32'h0,        32'hFFFF_FFFC, 32'h0,        3'b000, 2'd0, 32'h0,        1'b1, 32'h0000_0000};
    vecs[3]  = '{1'b1, 2'b10, 5'd0,  32'h0,        32'hFFFF_FFFC, 32'h0,        3'b000, 2'd0, 32'h0,        1'b0, 32'h0000_0000};
    vecs[4]  = '{1'b1, 2'b11, 5'd7,  32'h0,        32'h0,        32'hABCD_E000, 3'b000, 2'd0, 32'h0,        1'b1, 32'hABCD_E000};
    vecs[5]  = '{1'b1, 2'b01, 5'd8,  32'h0,        32'h0,        32'h0,        3'b000, 2'd1, 32'h1234_80FF, 1'b1, 32'hFFFF_FF80};
    vecs[6]  = '{1'b1, 2'b01, 5'd8,  32'h0,        32'h0,        32'h0,        3'b100, 2'd0, 32'h1234_80FF, 1'b1, 32'h0000_00FF};
    vecs[7]  = '{1'b1, 2'b01, 5'd13, 32'h0,        32'h0,        32'h0,        3'b001, 2'd3, 32'h8001_7FFF, 1'b1, 32'hFFFF_8001};
    vecs[8]  = '{1'b1, 2'b01, 5'd14, 32'h0,        32'h0,        32'h0,        3'b010, 2'd2, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
    vecs[9]  = '{1'b1, 2'b01, 5'd15, 32'h0,        32'h0,        32'h0,        3'b011, 2'd0, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000};
    vecs[10] = '{1'b0, 2'b00, 5'd9,  32'h5555_AAAA, 32'h0,        32'h0,        3'b000, 2'd0, 32'h0,        1'b0, 32'h5555_AAAA};
    vecs[11] = '{1'b1, 2'b01, 5'd31, 32'h0,        32'h0,        32'h0,        3'b001, 2'd0, 32'h1234_F00D, 1'b1, 32'hFFFF_F00D};

    v = vecs[0];
    drive(v, 1'b0);
    idle_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_write("reset", 1'b0, 5'd0, 32'h0);
    check("reset ready", 32'(bus.ready_o), 32'd1);

    // Single-cycle results: write the cycle after accept, then the slot closes.
    for (int i = 0; i < NumVec; i++) begin
      drive(vecs[i], 1'b1);
      tick();
      check_write($sformatf("vec%0d", i), vecs[i].we, vecs[i].rd, vecs[i].data);
      idle_in();
      tick();
      check($sformatf("vec%0d after we", i), 32'(bus.rf_we_o), 32'd0);
      check($sformatf("vec%0d ready", i), 32'(bus.ready_o), 32'd1);
    end

    // LB at offset 3 with data three cycles late.
    v = '{1'b1, 2'b01, 5'd10, 32'h0, 32'h0, 32'h0, 3'b000, 2'd3, 32'h80FF_0000, 1'b1,
          32'hFFFF_FF80};
    drive(v, 1'b0);
    tick();
    idle_in();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall%0d ready", k), 32'(bus.ready_o), 32'd0);
      check($sformatf("stall%0d we", k), 32'(bus.rf_we_o), 32'd0);
      if (k == 2) bus.load_valid_i = 1'b1;
      if (k < 2) tick();
    end
    tick();
    bus.load_valid_i = 1'b0;
    check_write("late lb", 1'b1, 5'd10, 32'hFFFF_FF80);
    check("late lb ready", 32'(bus.ready_o), 32'd1);
    tick();
    check("late lb after we", 32'(bus.rf_we_o), 32'd0);

    // Four back-to-back ALU ops.
    v = '{1'b1, 2'b00, 5'd11, 32'h0000_0100, 32'h0, 32'h0, 3'b000, 2'd0, 32'h0, 1'b1, 32'h0};
    drive(v, 1'b0);
    tick();
    for (int k = 1; k <= 4; k++) begin
      check_write($sformatf("b2b%0d", k - 1), 1'b1, 5'(11 + k - 1), 32'h100 + 32'(k - 1));
      check($sformatf("b2b%0d ready", k - 1), 32'(bus.ready_o), 32'd1);
      if (k < 4) begin
        v.rd  = 5'(11 + k);
        v.alu = 32'h100 + 32'(k);
        drive(v, 1'b0);
      end else begin
        idle_in();
      end
      tick();
    end
    check("b2b end we", 32'(bus.rf_we_o), 32'd0);

    // Reset while waiting for a load; the late data must be dropped.
    v = '{1'b1, 2'b01, 5'd12, 32'h0, 32'h0, 32'h0, 3'b010, 2'd0, 32'hCAFE_F00D, 1'b1, 32'h0};
    drive(v, 1'b0);
    tick();
    idle_in();
    check("rst-load wait ready", 32'(bus.ready_o), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst-load ready", 32'(bus.ready_o), 32'd1);
    check("rst-load we", 32'(bus.rf_we_o), 32'd0);
    bus.load_valid_i = 1'b1;
    tick();
    bus.load_valid_i = 1'b0;
    check("rst-load late we", 32'(bus.rf_we_o), 32'd0);
    check("rst-load late ready", 32'(bus.ready_o), 32'd1);
    tick();
    check("rst-load late we2", 32'(bus.rf_we_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
